// File: rtl/mso_capture_pkg.sv
// Shared types for the analogue trigger-and-capture stage.
package mso_capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } capture_state_t;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port ring buffer: one write port, one registered read port.
module capture_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    // Output register reset maps onto the block RAM output-latch reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/analogue_capture.sv
// Trigger detection with hysteresis and pre/post-trigger window capture
// into a ring buffer, read out relative to the window start.
module analogue_capture
    import mso_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic [DATA_WIDTH-1:0] trig_hyst,
    input  logic                  trig_falling,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr
);

    capture_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] pre_len_q, pre_len_d;
    logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
    logic                  trig_q, trig_d;
    logic                  qual_q, qual_d;
    logic                  force_q, force_d;

    logic [ADDR_WIDTH-1:0] cnt_inc, post_len, rd_phys;
    logic [DATA_WIDTH:0]   lo_ext, hi_ext;
    logic [DATA_WIDTH-1:0] lo, hi;
    logic                  capturing, wr_en, qual_set, level_hit, fire;

    // Thresholds are one bit wider so under/overflow can be saturated.
    assign lo_ext = {1'b0, trig_level} - {1'b0, trig_hyst};
    assign hi_ext = {1'b0, trig_level} + {1'b0, trig_hyst};
    assign lo     = lo_ext[DATA_WIDTH] ? '0 : lo_ext[DATA_WIDTH-1:0];
    assign hi     = hi_ext[DATA_WIDTH] ? '1 : hi_ext[DATA_WIDTH-1:0];

    assign qual_set  = (trig_falling == EDGE_FALLING) ? (sample_data > hi)
                                                      : (sample_data < lo);
    assign level_hit = (trig_falling == EDGE_FALLING) ? (sample_data <= trig_level)
                                                      : (sample_data >= trig_level);
    assign fire      = sample_valid && (force_trig || force_q || (qual_q && level_hit));

    assign capturing = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign wr_en     = sample_valid && capturing && !arm;
    assign cnt_inc   = cnt_q + ADDR_WIDTH'(1);
    assign post_len  = {ADDR_WIDTH{1'b1}} - pre_len_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        pre_len_d   = pre_len_q;
        trig_addr_d = trig_addr_q;
        trig_d      = trig_q;
        qual_d      = qual_q;
        force_d     = force_q;
        if (arm) begin
            // pretrig_len is ADDR_WIDTH wide, so it can never exceed DEPTH-1.
            wr_ptr_d  = '0;
            cnt_d     = '0;
            trig_d    = 1'b0;
            qual_d    = 1'b0;
            force_d   = 1'b0;
            pre_len_d = pretrig_len;
            state_d   = (pretrig_len == '0) ? ARMED : PRE;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            case (state_q)
                PRE: begin
                    if (sample_valid) begin
                        if (cnt_inc == pre_len_q) begin
                            cnt_d   = '0;
                            qual_d  = 1'b0;
                            force_d = 1'b0;
                            state_d = ARMED;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ARMED: begin
                    if (fire) begin
                        trig_addr_d = wr_ptr_q;
                        trig_d      = 1'b1;
                        cnt_d       = '0;
                        force_d     = 1'b0;
                        state_d     = (post_len == '0) ? DONE : POST;
                    end else begin
                        if (force_trig) force_d = 1'b1;
                        if (sample_valid && qual_set) qual_d = 1'b1;
                    end
                end
                POST: begin
                    if (sample_valid) begin
                        if (cnt_inc == post_len) state_d = DONE;
                        else                     cnt_d   = cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            pre_len_q   <= '0;
            trig_addr_q <= '0;
            trig_q      <= 1'b0;
            qual_q      <= 1'b0;
            force_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            pre_len_q   <= pre_len_d;
            trig_addr_q <= trig_addr_d;
            trig_q      <= trig_d;
            qual_q      <= qual_d;
            force_q     <= force_d;
        end
    end

    // Window start is pre_len samples behind the trigger, modulo DEPTH.
    assign rd_phys = trig_addr_q - pre_len_q + rd_addr;

    capture_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample_data),
        .raddr_i (rd_phys),
        .rdata_o (rd_data)
    );

    assign busy      = capturing;
    assign done      = (state_q == DONE);
    assign triggered = trig_q;
    assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_analogue_capture.sv
// Directed bench for analogue_capture with a 16-entry ring buffer.
module tb_analogue_capture;

    localparam int DW = 12;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, sample_valid, arm, force_trig, trig_falling;
    logic [DW-1:0] sample_data, trig_level, trig_hyst, rd_data;
    logic [AW-1:0] pretrig_len, rd_addr, trig_addr;
    logic          busy, triggered, done;

    int checks   = 0;
    int failures = 0;

    analogue_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .arm          (arm),
        .force_trig   (force_trig),
        .trig_level   (trig_level),
        .trig_hyst    (trig_hyst),
        .trig_falling (trig_falling),
        .pretrig_len  (pretrig_len),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done),
        .trig_addr    (trig_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [AW-1:0] pre);
        arm         = 1'b1;
        pretrig_len = pre;
        tick();
        arm = 1'b0;
    endtask

    task automatic read(input logic [AW-1:0] a, output logic [DW-1:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_valid = 1'b1; sample_data = 12'd123;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", busy); end
        checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL reset_triggered got=%0d exp=0", triggered); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0d exp=0", done); end
        checks++; if (trig_addr !== 4'd0) begin failures++; $display("FAIL reset_trig_addr got=%0d exp=0", trig_addr); end
        checks++; if (rd_data !== 12'd0) begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
        rst = 1'b0;
        repeat (2) tick();
        sample_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0d exp=0", busy); end
    endtask

    task automatic test_rising();
        logic [DW-1:0] d;
        trig_falling = 1'b0; trig_level = 12'd2048; trig_hyst = 12'd100;
        do_arm(4'd4);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rise_busy got=%0d exp=1", busy); end
        for (int v = 1600; v <= 2000; v += 50) send(DW'(v));
        checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL rise_early got=%0d exp=0", triggered); end
        send(12'd2050);
        checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL rise_trig got=%0d exp=1", triggered); end
        checks++; if (trig_addr !== 4'd9) begin failures++; $display("FAIL rise_trig_addr got=%0d exp=9", trig_addr); end
        for (int v = 2100; v <= 2550; v += 50) send(DW'(v));
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rise_post10 done=%0d busy=%0d exp done=0 busy=1", done, busy); end
        send(12'd2600);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rise_done done=%0d busy=%0d exp done=1 busy=0", done, busy); end
        send(12'd7);
        read(4'd4, d);
        checks++; if (d !== 12'd2050) begin failures++; $display("FAIL rise_rd4 got=%0d exp=2050", d); end
        read(4'd0, d);
        checks++; if (d !== 12'd1850) begin failures++; $display("FAIL rise_rd0 got=%0d exp=1850", d); end
        read(4'd15, d);
        checks++; if (d !== 12'd2600) begin failures++; $display("FAIL rise_rd15 got=%0d exp=2600", d); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rise_done_hold got=%0d exp=1", done); end
    endtask

    task automatic test_hysteresis();
        logic [DW-1:0] d;
        trig_falling = 1'b0; trig_level = 12'd2048; trig_hyst = 12'd100;
        do_arm(4'd0);
        repeat (3) send(12'd2100);
        send(12'd2000);
        repeat (2) send(12'd2100);
        checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL hyst_no_trig got=%0d exp=0", triggered); end
        send(12'd1900);
        checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL hyst_qual_only got=%0d exp=0", triggered); end
        send(12'd2048);
        checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL hyst_trig got=%0d exp=1", triggered); end
        checks++; if (trig_addr !== 4'd7) begin failures++; $display("FAIL hyst_trig_addr got=%0d exp=7", trig_addr); end
        for (int i = 0; i < 14; i++) send(DW'(100 + i));
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL pre0_early_done got=%0d exp=0", done); end
        send(12'd114);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL pre0_done got=%0d exp=1", done); end
        read(4'd0, d);
        checks++; if (d !== 12'd2048) begin failures++; $display("FAIL pre0_rd0 got=%0d exp=2048", d); end
    endtask

    task automatic test_falling_force();
        trig_falling = 1'b1; trig_level = 12'd4000; trig_hyst = 12'd200;
        do_arm(4'd2);
        send(12'd4095); send(12'd4095);
        send(12'd4095); send(12'd3000); send(12'd4095); send(12'd100); send(12'd0);
        checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL fall_sat_no_trig got=%0d exp=0", triggered); end
        force_trig = 1'b1; tick(); force_trig = 1'b0;
        tick();
        checks++; if (triggered !== 1'b0) begin failures++; $display("FAIL force_wait got=%0d exp=0", triggered); end
        send(12'd1234);
        checks++; if (triggered !== 1'b1) begin failures++; $display("FAIL force_trig got=%0d exp=1", triggered); end
        checks++; if (trig_addr !== 4'd7) begin failures++; $display("FAIL force_trig_addr got=%0d exp=7", trig_addr); end
    endtask

    task automatic test_rearm();
        logic [DW-1:0] d;
        trig_falling = 1'b0; trig_level = 12'd2048; trig_hyst = 12'd100;
        send(12'd55);
        do_arm(4'd2);
        checks++; if (triggered !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL rearm_flags trig=%0d busy=%0d done=%0d exp 0 1 0", triggered, busy, done); end
        send(12'd500); send(12'd600); send(12'd700); send(12'd3000);
        checks++; if (triggered !== 1'b1 || trig_addr !== 4'd3) begin failures++; $display("FAIL rearm_trig trig=%0d addr=%0d exp 1 3", triggered, trig_addr); end
        for (int i = 1; i <= 13; i++) send(DW'(10 * i));
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rearm_done got=%0d exp=1", done); end
        read(4'd0, d);
        checks++; if (d !== 12'd600) begin failures++; $display("FAIL rearm_rd0 got=%0d exp=600", d); end
        read(4'd2, d);
        checks++; if (d !== 12'd3000) begin failures++; $display("FAIL rearm_rd2 got=%0d exp=3000", d); end
        read(4'd15, d);
        checks++; if (d !== 12'd130) begin failures++; $display("FAIL rearm_rd15 got=%0d exp=130", d); end
    endtask

    task automatic test_pre_max();
        logic [DW-1:0] d;
        do_arm(4'd15);
        for (int i = 0; i < 15; i++) send(DW'(10 * i));
        send(12'd1000);
        checks++; if (triggered !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL premax_armed trig=%0d busy=%0d exp 0 1", triggered, busy); end
        send(12'd2500);
        checks++; if (triggered !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL premax_done trig=%0d done=%0d busy=%0d exp 1 1 0", triggered, done, busy); end
        checks++; if (trig_addr !== 4'd0) begin failures++; $display("FAIL premax_trig_addr got=%0d exp=0", trig_addr); end
        read(4'd15, d);
        checks++; if (d !== 12'd2500) begin failures++; $display("FAIL premax_rd15 got=%0d exp=2500", d); end
        read(4'd14, d);
        checks++; if (d !== 12'd1000) begin failures++; $display("FAIL premax_rd14 got=%0d exp=1000", d); end
        read(4'd0, d);
        checks++; if (d !== 12'd10) begin failures++; $display("FAIL premax_rd0 got=%0d exp=10", d); end
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample_data = '0; arm = 1'b0; force_trig = 1'b0;
        trig_level = '0; trig_hyst = '0; trig_falling = 1'b0; pretrig_len = '0; rd_addr = '0;
        test_reset();
        test_rising();
        test_hysteresis();
        test_falling_force();
        test_rearm();
        test_pre_max();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
